serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial addition controller that time-shares one external 1-bit full adder (x,y,cin -> s,cout).
//  Latches two WIDTH-bit operands on a start request and feeds the adder one bit per cycle, LSB first.
//  Holds the running carry, assembles the sum and signals completion with a one-cycle done pulse.
//  Sits between a requester (start/done handshake) and the shared full-adder instance.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits; legal range 2..32
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  a        in   WIDTH  operand A, captured on accepted start
//  b        in   WIDTH  operand B, captured on accepted start
//  cin      in   1      carry into bit 0, captured on accepted start
//  busy     out  1      high in RUN and DONE
//  done     out  1      one-cycle pulse in DONE; result valid from this cycle
//  sum      out  WIDTH  result; held until the next accepted start
//  cout     out  1      carry out of bit WIDTH-1; held with sum
//  fa_x     out  1      to full adder x
//  fa_y     out  1      to full adder y
//  fa_cin   out  1      to full adder cin
//  fa_s     in   1      from full adder s
//  fa_cout  in   1      from full adder cout
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, sum, cout, fa_x, fa_y, fa_cin = 0; internal regs = 0.
//  States: IDLE -> RUN (start=1) ; RUN -> DONE (after WIDTH bit cycles) ; DONE -> IDLE (always).
//  Accept edge (IDLE, start=1): a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0, cout<=0, state<=RUN.
//  RUN (combinational): fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry; outside RUN all three = 0.
//  RUN edge: sum<={fa_s,sum[WIDTH-1:1]}; carry<=fa_cout; a_sh,b_sh >>1; cnt<=cnt+1.
//  Edge with cnt==WIDTH-1: also cout<=fa_cout, state<=DONE.
//  Latency: start sampled at edge k -> done=1 in cycle after edge k+WIDTH; IDLE again after k+WIDTH+1.
//  Min start-to-start spacing: WIDTH+2 cycles.
//  start in RUN or DONE: ignored, not queued; a/b/cin changes after acceptance have no effect.
//  start held high continuously: new operation accepted in each IDLE cycle (back-to-back).
//  Overflow: sum wraps modulo 2^WIDTH; cout reports carry out.
//  cnt width $clog2(WIDTH); never exceeds WIDTH-1.
//  rst asserted mid-operation: immediate return to reset values; partial result discarded; no done.
//  fa_s/fa_cout consumed only on RUN edges; the full adder is purely combinational with no added latency.
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined: extra input sub (1 bit), sampled on accepted start.
//   sub=1: b_sh<=~b and carry<=1 (cin ignored) -> sum=a-b mod 2^WIDTH; cout=1 means no borrow.
//   sub=0: identical to the undefined build.
//  SERIAL_ADD_SUB_EN undefined: no sub port; addition only.
// TESTING (WIDTH=4)
//  a=3,b=5,cin=0,start 1 cycle -> done pulse exactly 5 cycles after accept edge; sum=8,cout=0.
//  a=15,b=1,cin=0 -> sum=0,cout=1; a=15,b=15,cin=1 -> sum=15,cout=1.
//  start re-pulsed in RUN with a=1,b=1 -> ignored; first op result unchanged; no extra done.
//  rst asserted in 2nd RUN cycle -> busy,done,sum,cout,fa_* =0 at once; next start a=2,b=2 -> sum=4.
//  start held high 3 ops (a=1..3,b=1) -> done every 6 cycles; sums 2,3,4; fa_* =0 in IDLE/DONE.
//  SERIAL_ADD_SUB_EN: a=5,b=3,sub=1 -> sum=2,cout=1; a=3,b=5,sub=1 -> sum=14,cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving a shared 1-bit full adder; define SERIAL_ADD_SUB_EN for subtract
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, b_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q, carry_d, run, last;
`ifdef SERIAL_ADD_SUB_EN
  assign b_d     = sub ? ~b : b;
  assign carry_d = sub | cin;
`else
  assign b_d     = b;
  assign carry_d = cin;
`endif
  assign run    = state_q == RUN;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign fa_x   = run & a_q[0];
  assign fa_y   = run & b_q[0];
  assign fa_cin = run & carry_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b_d;
          carry_q <= carry_d;
          cnt_q   <= '0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            cout_q  <= fa_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench with a behavioural full adder closing the loop
module tb_serial_add_ctrl;
  localparam int W = 4;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout, fa_x, fa_y, fa_cin, fa_s, fa_cout;
  logic [W-1:0] sum;
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );
  assign fa_s    = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_cin & (fa_x ^ fa_y));
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc++;
  typedef struct {logic [W-1:0] s; logic c; int t;} exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!busy || done) chk("fa_quiet", {29'd0, fa_x, fa_y, fa_cin}, 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_done: got done with sum %0h, required no done (cycle %0d)", sum, cyc);
        end else begin
          e = q.pop_front();
          chk("sum", {28'd0, sum}, {28'd0, e.s});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("done_cycle", cyc, e.t);
        end
      end
    end
  end
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input logic si, input logic [W-1:0] es, input logic ec);
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (busy) begin checks++; errors++; $display("FAIL issue_wait: busy stuck 1, required 0"); end
    a = ai; b = bi; cin = ci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = si;
`endif
    q.push_back('{es, ec, cyc + 1 + W});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_sum"}, {28'd0, sum}, 0);
    chk({tag, "_cout"}, {31'd0, cout}, 0);
    chk({tag, "_fa"}, {29'd0, fa_x, fa_y, fa_cin}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    issue(4'd3, 4'd5, 1'b0, 1'b0, 4'd8, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    issue(4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1);
    issue(4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1);
    issue(4'd6, 4'd9, 1'b0, 1'b0, 4'd15, 1'b0);
    drain();
    a = 4'd7; b = 4'd8; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(4'd2, 4'd2, 1'b0, 1'b0, 4'd4, 1'b0);
    drain();
    a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
    q.push_back('{4'd2, 1'b0, cyc + 1 + W});
    repeat (6) @(negedge clk);
    a = 4'd2;
    q.push_back('{4'd3, 1'b0, cyc + 1 + W});
    repeat (6) @(negedge clk);
    a = 4'd3;
    q.push_back('{4'd4, 1'b0, cyc + 1 + W});
    repeat (6) @(negedge clk);
    start = 1'b0;
    drain();
`ifdef SERIAL_ADD_SUB_EN
    issue(4'd5, 4'd3, 1'b0, 1'b1, 4'd2, 1'b1);
    issue(4'd3, 4'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    issue(4'd3, 4'd5, 1'b0, 1'b0, 4'd8, 1'b0);
    drain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
